imul_sequencer: RTL
===================

# imul_sequencer

Sequential control stage wrapped around the combinational 16x16 unsigned array multiplier in the execute path. It captures operands on a start strobe and holds them stable on the multiplier inputs for a fixed number of settling cycles. It then latches the 32-bit product and writes it back to the register file as two 16-bit writes, low half first. It gives the multicycle multiplier a clean handshake toward the instruction sequencer.

## Interface

**Parameters**
- LATENCY, 2: settling cycles allowed for the multiplier; legal range 1..15; elaboration fails outside that range.
- AW, 8: register-file address width.

**Ports**
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- iStart  in  1  start request; sampled only in IDLE.
- iA  in  16  multiplicand.
- iB  in  16  multiplier.
- iDestAddr  in  AW  destination register for the low half.
- oMulA  out  16  registered operand to the multiplier A input.
- oMulB  out  16  registered operand to the multiplier B input.
- iMulResult  in  32  product from the multiplier.
- oBusy  out  1  high in every state except IDLE.
- oWriteEnable  out  1  register-file write strobe.
- oWriteAddr  out  AW  register-file write address.
- oWriteData  out  16  register-file write data.
- oDone  out  1  one-cycle pulse coincident with the high-half write.

## Operation

- FSM states:
  - IDLE, SETTLE, WR_LO, WR_HI.
  - Encoding is free; no illegal state may lock up, and any unreachable code returns to IDLE.
- IDLE:
  - On iStart=1: latch iA into oMulA, iB into oMulB, iDestAddr into an internal address register.
  - Load the settle counter with LATENCY-1 and go to SETTLE.
  - On iStart=0: hold all registers.
- SETTLE:
  - Decrement the counter each cycle while it is nonzero.
  - At count 0, latch iMulResult into a 32-bit product register and go to WR_LO.
  - SETTLE therefore lasts exactly LATENCY cycles.
- WR_LO:
  - oWriteEnable=1, oWriteAddr=dest, oWriteData=product[15:0].
  - Next state WR_HI.
- WR_HI:
  - oWriteEnable=1, oWriteAddr=dest+1 modulo 2^AW (0xFF wraps to 0x00), oWriteData=product[31:16], oDone=1.
  - Next state IDLE.
- iStart outside IDLE is ignored. It is not queued, and operand inputs are not sampled.
- oMulA and oMulB change only on an accepted start. They hold their last value after completion.
- Outside WR_LO/WR_HI: oWriteEnable=0, oWriteAddr=0, oWriteData=0, oDone=0.
- All outputs are registered, or decoded only from registered state. There is no combinational path from any input to any output.
- Arithmetic is unsigned. The product register is 32 bits and nothing is truncated.

## Timing

- Reset asserted: state=IDLE, counter=0, product=0, dest=0. Every output is 0: oMulA, oMulB, oBusy, oWriteEnable, oWriteAddr, oWriteData, oDone. This takes effect immediately, without waiting for Clock.
- Reset mid-operation aborts the operation. No further write is issued, and a pending high-half write is dropped even if the low half was already written.
- Take iStart=1 sampled at edge k:
  - oBusy=1 from cycle k+1.
  - SETTLE occupies cycles k+1..k+LATENCY.
  - WR_LO is cycle k+LATENCY+1.
  - WR_HI (with oDone) is cycle k+LATENCY+2.
  - IDLE with oBusy=0 resumes at cycle k+LATENCY+3.
- The earliest next start is sampled at edge k+LATENCY+3, giving a throughput of one multiply per LATENCY+3 cycles.
- iMulResult is sampled only on the final SETTLE edge. Its value at any other time is don't-care.

## Test plan

- LATENCY=2, start at edge 0 with A=3, B=5, dest=0x10:
  - Cycle 3: WE=1, addr 0x10, data 0x000F.
  - Cycle 4: WE=1, addr 0x11, data 0x0000, oDone=1.
  - Cycle 5: oBusy=0.
- A=0xFFFF, B=0xFFFF, dest=0x20 → low write 0x0001 to 0x20, high write 0xFFFE to 0x21.
- dest=0xFF, A=0x1234, B=0x0100 → 0x3400 written to 0xFF, then 0x0012 written to 0x00.
- iStart held high continuously with changing operands → accepts only at edges 0, 5, 10 (LATENCY=2). Each result matches the operands present at its accept edge. Exactly two writes per accept.
- Reset pulsed low during SETTLE, then again between WR_LO and WR_HI → all outputs 0 immediately, no further writes, oDone never pulses. After release, a new start completes normally.
- LATENCY=1 and LATENCY=15 builds → write cycles at k+2/k+3 and k+16/k+17 respectively, with correct products checked against A*B.

Source files
------------

// File: rtl/imul_sequencer.sv
// Multicycle control around a combinational 16x16 unsigned multiplier:
// capture operands, wait LATENCY settling cycles, write the 32-bit product back as two halves.
module imul_sequencer #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned AW      = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          iStart,
  input  logic [15:0]   iA,
  input  logic [15:0]   iB,
  input  logic [AW-1:0] iDestAddr,
  output logic [15:0]   oMulA,
  output logic [15:0]   oMulB,
  input  logic [31:0]   iMulResult,
  output logic          oBusy,
  output logic          oWriteEnable,
  output logic [AW-1:0] oWriteAddr,
  output logic [15:0]   oWriteData,
  output logic          oDone
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("imul_sequencer: LATENCY must be within 1..15");
  end

  typedef enum logic [1:0] {IDLE, SETTLE, WR_LO, WR_HI} state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    count;
  logic [31:0]   product;
  logic [AW-1:0] dest;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    oBusy        = 1'b1;
    oWriteEnable = 1'b0;
    oWriteAddr   = '0;
    oWriteData   = '0;
    oDone        = 1'b0;
    case (state)
      IDLE: begin
        oBusy = 1'b0;
        if (iStart) state_next = SETTLE;
      end
      SETTLE: begin
        if (count == '0) state_next = WR_LO;
      end
      WR_LO: begin
        oWriteEnable = 1'b1;
        oWriteAddr   = dest;
        oWriteData   = product[15:0];
        state_next   = WR_HI;
      end
      WR_HI: begin
        oWriteEnable = 1'b1;
        oWriteAddr   = dest + AW'(1);
        oWriteData   = product[31:16];
        oDone        = 1'b1;
        state_next   = IDLE;
      end
      default: begin
        oBusy      = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // Operands stay on the multiplier inputs until the next accepted start.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oMulA   <= '0;
      oMulB   <= '0;
      dest    <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            oMulA <= iA;
            oMulB <= iB;
            dest  <= iDestAddr;
            count <= 4'(LATENCY - 1);
          end
        end
        SETTLE: begin
          if (count != '0) count   <= count - 4'd1;
          else             product <= iMulResult;
        end
        default: ;
      endcase
    end
  end

endmodule
